// File: rtl/fpu_pkg.sv
// Shared FPU definitions: exponent biases, special encodings,
// rounding modes, FSM states and small helpers for the x87 datapath.
package fpu_pkg;

    // Exponent biases of the two formats and the rebias step between them
    localparam int EXT_BIAS        = 16383;
    localparam int DBL_BIAS        = 1023;
    localparam int EXT_TO_DBL_ADJ  = EXT_BIAS - DBL_BIAS;

    // Special exponent encodings
    localparam logic [14:0] EXT_EXP_SPECIAL = 15'h7FFF;
    localparam logic [14:0] EXT_EXP_ZERO    = 15'h0000;
    localparam logic [10:0] DBL_EXP_SPECIAL = 11'h7FF;
    localparam logic [16:0] DBL_EXP_OVF     = 17'd2047;

    // Extended significand of an infinity (explicit integer bit only)
    localparam logic [63:0] EXT_INF_MANT = 64'h8000_0000_0000_0000;

    // binary64 magnitudes (sign supplied separately)
    localparam logic [62:0] DBL_INF_MAG  = 63'h7FF0_0000_0000_0000;
    localparam logic [62:0] DBL_MAX_MAG  = 63'h7FEF_FFFF_FFFF_FFFF;
    localparam logic [62:0] DBL_QNAN_MAG = 63'h7FF8_0000_0000_0000;

    typedef enum logic [1:0] {
        RM_RN = 2'b00,
        RM_RD = 2'b01,
        RM_RU = 2'b10,
        RM_RZ = 2'b11
    } rmode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_ALIGN,
        ST_ROUND,
        ST_PACK
    } state_e;

    typedef struct packed {
        logic inv;
        logic ovf;
        logic unf;
        logic inx;
    } flags_t;

    // Overflowed result: infinity, or max finite when the rounding
    // direction points back toward zero.
    function automatic logic [63:0] ovf_result(input logic sign,
                                               input rmode_e rm);
        logic to_max;
        to_max = (rm == RM_RZ)
              || ((rm == RM_RD) && !sign)
              || ((rm == RM_RU) && sign);
        return {sign, (to_max ? DBL_MAX_MAG : DBL_INF_MAG)};
    endfunction

endpackage

// File: rtl/fpu_ext_to_double_if.sv
// Enable/done pulse bus of the extended-to-double converter.
// master: requester (enable, operand, mode); slave: converter (result, flags).
interface fpu_ext_to_double_if;

    logic        enable;
    logic [79:0] operand_in;
    logic [1:0]  rounding_mode;
    logic [63:0] result;
    logic        done;
    logic        flag_invalid;
    logic        flag_overflow;
    logic        flag_underflow;
    logic        flag_inexact;

    modport master (
        output enable,
        output operand_in,
        output rounding_mode,
        input  result,
        input  done,
        input  flag_invalid,
        input  flag_overflow,
        input  flag_underflow,
        input  flag_inexact
    );

    modport slave (
        input  enable,
        input  operand_in,
        input  rounding_mode,
        output result,
        output done,
        output flag_invalid,
        output flag_overflow,
        output flag_underflow,
        output flag_inexact
    );

endinterface

// File: rtl/fpu_shift_right_sticky.sv
// Combinational right shifter that also reports the OR of shifted-out bits.
// Ports: i_data/i_shamt in; o_data (shifted), o_sticky (lost bits nonzero).
module fpu_shift_right_sticky #(
    parameter int WIDTH = 54,
    parameter int SHW   = 17
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [SHW-1:0]   i_shamt,
    output logic [WIDTH-1:0] o_data,
    output logic             o_sticky
);

    logic [WIDTH-1:0] w_lost_mask;

    // Shift amounts >= WIDTH give an all-ones mask, so every bit is lost
    assign w_lost_mask = ~({WIDTH{1'b1}} << i_shamt);
    assign o_data      = i_data >> i_shamt;
    assign o_sticky    = |(i_data & w_lost_mask);

endmodule

// File: rtl/fpu_ext_to_double.sv
// Converts an 80-bit extended value to binary64 with x87 rounding and flags.
// Ports: clk, reset (async, high), bus (slave: enable/operand/mode -> result/done/flags).
module fpu_ext_to_double #(
    parameter logic INDEF_SIGN = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    fpu_ext_to_double_if.slave  bus
);

    import fpu_pkg::*;

    state_e      r_state;
    state_e      w_next;

    logic        r_sign;
    logic [14:0] r_exp;
    logic [63:0] r_mant;
    logic [52:0] r_sig;
    logic        r_guard;
    logic        r_sticky;
    logic [16:0] r_de;
    logic        r_tiny;
    logic        r_ovf;
    logic        r_inx;
    logic        r_unf;
    logic [63:0] r_ovf_res;
    logic [63:0] r_result;
    logic        r_done;
    flags_t      r_flags;

    // ---------------- UNPACK: classification of the raw input
    logic        w_in_sign;
    logic [14:0] w_in_exp;
    logic [63:0] w_in_mant;
    logic        w_in_max;
    logic        w_is_inf;
    logic        w_is_nan;
    logic        w_is_zero;
    logic        w_is_unn;
    logic        w_special;
    logic [63:0] w_spec_res;
    logic        w_spec_inv;

    assign w_in_sign = bus.operand_in[79];
    assign w_in_exp  = bus.operand_in[78:64];
    assign w_in_mant = bus.operand_in[63:0];
    assign w_in_max  = (w_in_exp == EXT_EXP_SPECIAL);
    assign w_is_inf  = w_in_max && (w_in_mant == EXT_INF_MANT);
    assign w_is_nan  = w_in_max && (w_in_mant != EXT_INF_MANT);
    assign w_is_zero = (w_in_exp == EXT_EXP_ZERO) && (w_in_mant == 64'd0);
    // Nonzero exponent without the explicit integer bit is unsupported
    assign w_is_unn  = !w_in_max && (w_in_exp != EXT_EXP_ZERO)
                    && !w_in_mant[63];
    assign w_special = w_is_inf || w_is_nan || w_is_zero || w_is_unn;

    always_comb begin
        w_spec_res = 64'd0;
        w_spec_inv = 1'b0;
        unique case (1'b1)
            w_is_inf: begin
                w_spec_res = {w_in_sign, DBL_INF_MAG};
            end
            w_is_nan: begin
                // Quiet bit forced; an SNaN is signalled as invalid
                w_spec_res = {w_in_sign, DBL_EXP_SPECIAL, 1'b1,
                              w_in_mant[61:11]};
                w_spec_inv = !w_in_mant[62];
            end
            w_is_zero: begin
                w_spec_res = {w_in_sign, 63'd0};
            end
            w_is_unn: begin
                w_spec_res = {INDEF_SIGN, DBL_QNAN_MAG};
                w_spec_inv = 1'b1;
            end
            default: begin
                w_spec_res = 64'd0;
                w_spec_inv = 1'b0;
            end
        endcase
    end

    // ---------------- ALIGN: rebias and denormalise tiny values
    logic [14:0]        w_exp_eff;
    logic signed [16:0] w_de;
    logic               w_tiny;
    logic [16:0]        w_shamt;
    logic [53:0]        w_sh_out;
    logic               w_sh_stk;
    logic               w_base_stk;

    // Extended denormals use the same scale as exponent 1
    assign w_exp_eff  = (r_exp == EXT_EXP_ZERO) ? 15'd1 : r_exp;
    assign w_de       = $signed({2'b00, w_exp_eff})
                      - $signed(17'(EXT_TO_DBL_ADJ));
    assign w_tiny     = w_de[16] || (w_de == 17'sd0);
    assign w_shamt    = 17'd1 - $unsigned(w_de);
    assign w_base_stk = |r_mant[9:0];

    // {sig, guard} is mant[63:10]
    fpu_shift_right_sticky #(
        .WIDTH (54),
        .SHW   (17)
    ) u_shift (
        .i_data   (r_mant[63:10]),
        .i_shamt  (w_shamt),
        .o_data   (w_sh_out),
        .o_sticky (w_sh_stk)
    );

    // ---------------- ROUND: increment decision and carry-out
    rmode_e      w_rm;
    logic        w_inx;
    logic        w_inc;
    logic [53:0] w_sum;
    logic [52:0] w_sig_r;
    logic [16:0] w_de_r;
    logic        w_ovf;

    assign w_rm  = rmode_e'(bus.rounding_mode);
    assign w_inx = r_guard || r_sticky;

    always_comb begin
        w_inc = 1'b0;
        unique case (w_rm)
            RM_RN: w_inc = r_guard && (r_sticky || r_sig[0]);
            RM_RD: w_inc = r_sign && w_inx;
            RM_RU: w_inc = !r_sign && w_inx;
            RM_RZ: w_inc = 1'b0;
            default: w_inc = 1'b0;
        endcase
    end

    assign w_sum   = {1'b0, r_sig} + {53'd0, w_inc};
    // Carry out of 2^53 renormalises; the dropped bit is always zero
    assign w_sig_r = w_sum[53] ? w_sum[53:1] : w_sum[52:0];
    assign w_de_r  = r_de + {16'd0, w_sum[53]};
    assign w_ovf   = (w_de_r >= DBL_EXP_OVF);

    // ---------------- PACK: field assembly
    logic [10:0] w_exp_field;
    logic [63:0] w_pack_res;

    // Tiny results become the min normal if rounding reached 2^52
    assign w_exp_field = r_tiny ? {10'd0, r_sig[52]} : r_de[10:0];
    assign w_pack_res  = r_ovf ? r_ovf_res
                               : {r_sign, w_exp_field, r_sig[51:0]};

    // ---------------- FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:   w_next = bus.enable ? ST_UNPACK : ST_IDLE;
            ST_UNPACK: w_next = w_special ? ST_IDLE : ST_ALIGN;
            ST_ALIGN:  w_next = ST_ROUND;
            ST_ROUND:  w_next = ST_PACK;
            ST_PACK:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // ---------------- Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sign    <= 1'b0;
            r_exp     <= 15'd0;
            r_mant    <= 64'd0;
            r_sig     <= 53'd0;
            r_guard   <= 1'b0;
            r_sticky  <= 1'b0;
            r_de      <= 17'd0;
            r_tiny    <= 1'b0;
            r_ovf     <= 1'b0;
            r_inx     <= 1'b0;
            r_unf     <= 1'b0;
            r_ovf_res <= 64'd0;
            r_result  <= 64'd0;
            r_done    <= 1'b0;
            r_flags   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_done  <= 1'b0;
                    r_flags <= '0;
                end
                ST_UNPACK: begin
                    r_sign <= w_in_sign;
                    r_exp  <= w_in_exp;
                    r_mant <= w_in_mant;
                    if (w_special) begin
                        r_result <= w_spec_res;
                        r_done   <= 1'b1;
                        r_flags  <= '{inv: w_spec_inv, ovf: 1'b0,
                                      unf: 1'b0, inx: 1'b0};
                    end
                end
                ST_ALIGN: begin
                    if (w_tiny) begin
                        r_sig    <= w_sh_out[53:1];
                        r_guard  <= w_sh_out[0];
                        r_sticky <= w_base_stk || w_sh_stk;
                        r_de     <= 17'd0;
                        r_tiny   <= 1'b1;
                    end else begin
                        r_sig    <= r_mant[63:11];
                        r_guard  <= r_mant[10];
                        r_sticky <= w_base_stk;
                        r_de     <= $unsigned(w_de);
                        r_tiny   <= 1'b0;
                    end
                end
                ST_ROUND: begin
                    r_sig     <= w_sig_r;
                    r_de      <= w_de_r;
                    r_ovf     <= w_ovf;
                    r_inx     <= w_inx || w_ovf;
                    r_unf     <= r_tiny && w_inx;
                    r_ovf_res <= ovf_result(r_sign, w_rm);
                end
                ST_PACK: begin
                    r_result <= w_pack_res;
                    r_done   <= 1'b1;
                    r_flags  <= '{inv: 1'b0, ovf: r_ovf,
                                  unf: r_unf, inx: r_inx};
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign bus.result         = r_result;
    assign bus.done           = r_done;
    assign bus.flag_invalid   = r_flags.inv;
    assign bus.flag_overflow  = r_flags.ovf;
    assign bus.flag_underflow = r_flags.unf;
    assign bus.flag_inexact   = r_flags.inx;

endmodule

// File: tb/tb_fpu_ext_to_double.sv
// Self-checking bench for fpu_ext_to_double: vector table with a
// scoreboard queue, plus reset-abort, busy-enable and back-to-back runs.
module tb_fpu_ext_to_double;

    localparam logic [1:0] RN = 2'b00;
    localparam logic [1:0] RD = 2'b01;
    localparam logic [1:0] RU = 2'b10;
    localparam logic [1:0] RZ = 2'b11;

    typedef struct {
        logic [79:0] op;
        logic [1:0]  rm;
        logic [63:0] res;
        logic [3:0]  flg;   // {invalid, overflow, underflow, inexact}
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fpu_ext_to_double_if bus();

    fpu_ext_to_double #(
        .INDEF_SIGN (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    wire [3:0] w_flg = {bus.flag_invalid, bus.flag_overflow,
                        bus.flag_underflow, bus.flag_inexact};

    vec_t tv[$];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_one(input vec_t v, input string name);
        vec_t e;
        int   cyc;
        bit   seen;
        sb.push_back(v);
        @(negedge clk);
        bus.operand_in    = v.op;
        bus.rounding_mode = v.rm;
        bus.enable        = 1'b1;
        seen = 1'b0;
        cyc  = 0;
        for (int c = 1; c <= 12 && !seen; c++) begin
            @(negedge clk);
            bus.enable = 1'b0;
            if (bus.done) begin
                seen = 1'b1;
                cyc  = c;
            end
        end
        e = sb.pop_front();
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: no done within 12 cycles", name);
        end else begin
            chk({name, " result"}, bus.result, e.res);
            chk({name, " flags"}, 64'(w_flg), 64'(e.flg));
            chk({name, " latency"}, 64'(cyc), 64'(e.lat));
            @(negedge clk);
            chk({name, " pulse end"}, 64'({bus.done, w_flg}), 64'd0);
        end
    endtask

    initial begin
        vec_t e;
        vec_t ops[3];
        int   k;
        int   t_exp;
        int   n_done;
        bit   prev;

        reset             = 1'b1;
        bus.enable        = 1'b0;
        bus.operand_in    = 80'd0;
        bus.rounding_mode = RN;

        tv.push_back('{80'h3FFF_8000_0000_0000_0000, RN, 64'h3FF0_0000_0000_0000, 4'b0000, 5});
        tv.push_back('{80'h3FFF_FFFF_FFFF_FFFF_FFFF, RN, 64'h4000_0000_0000_0000, 4'b0001, 5});
        tv.push_back('{80'h3FFF_FFFF_FFFF_FFFF_FFFF, RZ, 64'h3FFF_FFFF_FFFF_FFFF, 4'b0001, 5});
        tv.push_back('{80'h7FFE_8000_0000_0000_0000, RN, 64'h7FF0_0000_0000_0000, 4'b0101, 5});
        tv.push_back('{80'h7FFE_8000_0000_0000_0000, RZ, 64'h7FEF_FFFF_FFFF_FFFF, 4'b0101, 5});
        tv.push_back('{80'hFFFE_8000_0000_0000_0000, RU, 64'hFFEF_FFFF_FFFF_FFFF, 4'b0101, 5});
        tv.push_back('{80'h7FFE_8000_0000_0000_0000, RD, 64'h7FEF_FFFF_FFFF_FFFF, 4'b0101, 5});
        tv.push_back('{80'hFFFE_8000_0000_0000_0000, RN, 64'hFFF0_0000_0000_0000, 4'b0101, 5});
        tv.push_back('{80'h3BCD_8000_0000_0000_0000, RN, 64'h0000_0000_0000_0001, 4'b0000, 5});
        tv.push_back('{80'h3BCC_8000_0000_0000_0000, RN, 64'h0000_0000_0000_0000, 4'b0011, 5});
        tv.push_back('{80'h3BCC_8000_0000_0000_0000, RU, 64'h0000_0000_0000_0001, 4'b0011, 5});
        tv.push_back('{80'h3C00_8000_0000_0000_0000, RN, 64'h0008_0000_0000_0000, 4'b0000, 5});
        tv.push_back('{80'h3C00_FFFF_FFFF_FFFF_FFFF, RN, 64'h0010_0000_0000_0000, 4'b0011, 5});
        tv.push_back('{80'h0000_8000_0000_0000_0000, RU, 64'h0000_0000_0000_0001, 4'b0011, 5});
        tv.push_back('{80'h43FE_8000_0000_0000_0000, RN, 64'h7FE0_0000_0000_0000, 4'b0000, 5});
        tv.push_back('{80'h43FE_FFFF_FFFF_FFFF_FFFF, RN, 64'h7FF0_0000_0000_0000, 4'b0101, 5});
        tv.push_back('{80'hBFFF_8000_0000_0000_0001, RD, 64'hBFF0_0000_0000_0001, 4'b0001, 5});
        tv.push_back('{80'hBFFF_8000_0000_0000_0001, RU, 64'hBFF0_0000_0000_0000, 4'b0001, 5});
        tv.push_back('{80'h3FFF_8000_0000_0000_0C00, RN, 64'h3FF0_0000_0000_0002, 4'b0001, 5});
        tv.push_back('{80'h7FFF_A000_0000_0000_0000, RN, 64'h7FFC_0000_0000_0000, 4'b1000, 2});
        tv.push_back('{80'hFFFF_C000_0000_0000_0000, RN, 64'hFFF8_0000_0000_0000, 4'b0000, 2});
        tv.push_back('{80'hFFFF_8000_0000_0000_0000, RN, 64'hFFF0_0000_0000_0000, 4'b0000, 2});
        tv.push_back('{80'h4000_0000_0000_0000_0001, RN, 64'hFFF8_0000_0000_0000, 4'b1000, 2});
        tv.push_back('{80'h8000_0000_0000_0000_0000, RN, 64'h8000_0000_0000_0000, 4'b0000, 2});

        repeat (3) @(negedge clk);
        chk("reset result", bus.result, 64'd0);
        chk("reset done/flags", 64'({bus.done, w_flg}), 64'd0);
        reset = 1'b0;

        foreach (tv[i]) begin
            run_one(tv[i], $sformatf("vec%0d", i));
        end

        // Reset asserted while the converter sits in ALIGN
        @(negedge clk);
        bus.operand_in    = tv[0].op;
        bus.rounding_mode = tv[0].rm;
        bus.enable        = 1'b1;
        @(negedge clk);
        bus.enable = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort result", bus.result, 64'd0);
        @(negedge clk);
        reset  = 1'b0;
        n_done = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        chk("abort no done", 64'(n_done), 64'd0);
        chk("abort result held", bus.result, 64'd0);

        // Enable toggled while busy must not start a second conversion
        sb.push_back(tv[1]);
        @(negedge clk);
        bus.operand_in    = tv[1].op;
        bus.rounding_mode = tv[1].rm;
        bus.enable        = 1'b1;
        n_done = 0;
        k      = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            bus.enable = (c >= 2 && c <= 4) ? c[0] == 1'b0 : 1'b0;
            if (bus.done) begin
                n_done++;
                if (n_done == 1) begin
                    k = c;
                    e = sb.pop_front();
                    chk("busy result", bus.result, e.res);
                end
            end
        end
        chk("busy done count", 64'(n_done), 64'd1);
        chk("busy latency", 64'(k), 64'd5);

        // Enable held high: back-to-back conversions
        ops[0] = tv[0];
        ops[1] = tv[8];
        ops[2] = tv[19];
        @(negedge clk);
        bus.operand_in    = ops[0].op;
        bus.rounding_mode = ops[0].rm;
        bus.enable        = 1'b1;
        sb.push_back(ops[0]);
        k      = 0;
        t_exp  = ops[0].lat;
        n_done = 0;
        prev   = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (bus.done && prev) begin
                n_vec++;
                n_err++;
                $display("FAIL b2b pulse: done high two cycles at %0d", c);
            end
            prev = bus.done;
            if (bus.done) begin
                n_done++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk($sformatf("b2b%0d result", k), bus.result, e.res);
                    chk($sformatf("b2b%0d flags", k), 64'(w_flg), 64'(e.flg));
                    chk($sformatf("b2b%0d cycle", k), 64'(c), 64'(t_exp));
                end
                k++;
                if (k < 3) begin
                    bus.operand_in    = ops[k].op;
                    bus.rounding_mode = ops[k].rm;
                    sb.push_back(ops[k]);
                    t_exp = t_exp + ops[k].lat;
                end else begin
                    bus.enable = 1'b0;
                end
            end
        end
        chk("b2b done count", 64'(n_done), 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
